// File: rtl/tx_upconverter.sv
// Four-lane transmit quadrature upconverter: dac = sat12(round((I*cos - Q*sin) / 2^19)).
// Three register stages (product, difference + rounding, shift + saturate) share one stall enable.
module tx_upconverter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [15:0] i0_i,
    input  logic [15:0] i1_i,
    input  logic [15:0] i2_i,
    input  logic [15:0] i3_i,
    input  logic [15:0] q0_i,
    input  logic [15:0] q1_i,
    input  logic [15:0] q2_i,
    input  logic [15:0] q3_i,
    input  logic [15:0] cos0_i,
    input  logic [15:0] cos1_i,
    input  logic [15:0] cos2_i,
    input  logic [15:0] cos3_i,
    input  logic [15:0] sin0_i,
    input  logic [15:0] sin1_i,
    input  logic [15:0] sin2_i,
    input  logic [15:0] sin3_i,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [11:0] dac0_o,
    output logic [11:0] dac1_o,
    output logic [11:0] dac2_o,
    output logic [11:0] dac3_o,
    output logic [3:0]  m_sat_o,
    input  logic        sat_clr_i,
    output logic [15:0] sat_count_o
);

    logic signed [15:0] i_a [4];
    logic signed [15:0] q_a [4];
    logic signed [15:0] c_a [4];
    logic signed [15:0] s_a [4];

    assign i_a[0] = i0_i;   assign i_a[1] = i1_i;   assign i_a[2] = i2_i;   assign i_a[3] = i3_i;
    assign q_a[0] = q0_i;   assign q_a[1] = q1_i;   assign q_a[2] = q2_i;   assign q_a[3] = q3_i;
    assign c_a[0] = cos0_i; assign c_a[1] = cos1_i; assign c_a[2] = cos2_i; assign c_a[3] = cos3_i;
    assign s_a[0] = sin0_i; assign s_a[1] = sin1_i; assign s_a[2] = sin2_i; assign s_a[3] = sin3_i;

    logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [31:0] pi_q [4];
    logic signed [31:0] pi_d [4];
    logic signed [31:0] pq_q [4];
    logic signed [31:0] pq_d [4];
    logic signed [32:0] r_q  [4];
    logic signed [32:0] r_d  [4];
    logic        [11:0] dac_q [4];
    logic        [11:0] dac_d [4];
    logic        [3:0]  sat_q, sat_d;
    logic        [15:0] cnt_q, cnt_d;

    logic               ce;
    logic signed [32:0] y_n   [4];
    logic        [11:0] dac_n [4];
    logic        [3:0]  sat_n;

    // Stage-3 combinational result, also used by the counter before it is registered.
    always_comb begin
        sat_n = '0;
        for (int l = 0; l < 4; l++) begin
            y_n[l]   = r_q[l] >>> 19;
            dac_n[l] = y_n[l][11:0];
            if (y_n[l] > 33'sd2047) begin
                dac_n[l] = 12'h7ff;
                sat_n[l] = 1'b1;
            end else if (y_n[l] < -33'sd2048) begin
                dac_n[l] = 12'h800;
                sat_n[l] = 1'b1;
            end
        end
    end

    always_comb begin
        ce    = !v3_q || m_ready_i;
        v1_d  = v1_q;
        v2_d  = v2_q;
        v3_d  = v3_q;
        sat_d = sat_q;
        cnt_d = cnt_q;
        for (int l = 0; l < 4; l++) begin
            pi_d[l]  = pi_q[l];
            pq_d[l]  = pq_q[l];
            r_d[l]   = r_q[l];
            dac_d[l] = dac_q[l];
        end
        if (ce) begin
            v1_d = s_valid_i;
            v2_d = v1_q;
            v3_d = v2_q;
            for (int l = 0; l < 4; l++) begin
                if (s_valid_i) begin
                    pi_d[l] = 32'(i_a[l]) * 32'(c_a[l]);
                    pq_d[l] = 32'(q_a[l]) * 32'(s_a[l]);
                end
                // 33 bits: the difference of two 2^30 products can reach +/-2^31.
                if (v1_q) begin
                    r_d[l] = 33'(pi_q[l]) - 33'(pq_q[l]) + 33'sd262144;
                end
                if (v2_q) begin
                    dac_d[l] = dac_n[l];
                end
            end
            if (v2_q) begin
                sat_d = sat_n;
            end
        end
        if (sat_clr_i) begin
            cnt_d = '0;
        end else if (ce && v2_q && (|sat_n) && (cnt_q != 16'hffff)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            sat_q <= '0;
            cnt_q <= '0;
            for (int l = 0; l < 4; l++) begin
                pi_q[l]  <= '0;
                pq_q[l]  <= '0;
                r_q[l]   <= '0;
                dac_q[l] <= '0;
            end
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            sat_q <= sat_d;
            cnt_q <= cnt_d;
            for (int l = 0; l < 4; l++) begin
                pi_q[l]  <= pi_d[l];
                pq_q[l]  <= pq_d[l];
                r_q[l]   <= r_d[l];
                dac_q[l] <= dac_d[l];
            end
        end
    end

    assign s_ready_o   = ce;
    assign m_valid_o   = v3_q;
    assign dac0_o      = dac_q[0];
    assign dac1_o      = dac_q[1];
    assign dac2_o      = dac_q[2];
    assign dac3_o      = dac_q[3];
    assign m_sat_o     = sat_q;
    assign sat_count_o = cnt_q;

endmodule

// File: tb/tb_tx_upconverter.sv
// Directed bench for tx_upconverter: a table of hand-computed lane vectors streamed through
// the pipeline, plus sequences for latency, stalls, counter clear/saturation and mid-stream reset.
module tb_tx_upconverter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [15:0] i0_i = '0, i1_i = '0, i2_i = '0, i3_i = '0;
    logic [15:0] q0_i = '0, q1_i = '0, q2_i = '0, q3_i = '0;
    logic [15:0] cos0_i = '0, cos1_i = '0, cos2_i = '0, cos3_i = '0;
    logic [15:0] sin0_i = '0, sin1_i = '0, sin2_i = '0, sin3_i = '0;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic [11:0] dac0_o, dac1_o, dac2_o, dac3_o;
    logic [3:0]  m_sat_o;
    logic        sat_clr_i = 1'b0;
    logic [15:0] sat_count_o;

    tx_upconverter dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .i0_i(i0_i), .i1_i(i1_i), .i2_i(i2_i), .i3_i(i3_i),
        .q0_i(q0_i), .q1_i(q1_i), .q2_i(q2_i), .q3_i(q3_i),
        .cos0_i(cos0_i), .cos1_i(cos1_i), .cos2_i(cos2_i), .cos3_i(cos3_i),
        .sin0_i(sin0_i), .sin1_i(sin1_i), .sin2_i(sin2_i), .sin3_i(sin3_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .dac0_o(dac0_o), .dac1_o(dac1_o), .dac2_o(dac2_o), .dac3_o(dac3_o),
        .m_sat_o(m_sat_o), .sat_clr_i(sat_clr_i), .sat_count_o(sat_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0][15:0] i;
        logic [3:0][15:0] q;
        logic [3:0][15:0] c;
        logic [3:0][15:0] s;
        logic [3:0][11:0] dac;
        logic [3:0]       sat;
    } vec_t;

    localparam int NV = 9;
    vec_t        vec [NV];
    logic [51:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    bit          cnt_chk = 1'b1;
    logic [51:0] snap;
    logic [51:0] out_w;

    assign out_w = {m_sat_o, dac3_o, dac2_o, dac1_o, dac0_o};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_lane(input int k, input int l, input int i, input int q, input int c,
                            input int s, input int d, input bit sat);
        vec[k].i[l]   = 16'(i);
        vec[k].q[l]   = 16'(q);
        vec[k].c[l]   = 16'(c);
        vec[k].s[l]   = 16'(s);
        vec[k].dac[l] = 12'(d);
        vec[k].sat[l] = sat;
    endtask

    task automatic drive_vec(input int k);
        i0_i = vec[k].i[0];   i1_i = vec[k].i[1];   i2_i = vec[k].i[2];   i3_i = vec[k].i[3];
        q0_i = vec[k].q[0];   q1_i = vec[k].q[1];   q2_i = vec[k].q[2];   q3_i = vec[k].q[3];
        cos0_i = vec[k].c[0]; cos1_i = vec[k].c[1]; cos2_i = vec[k].c[2]; cos3_i = vec[k].c[3];
        sin0_i = vec[k].s[0]; sin1_i = vec[k].s[1]; sin2_i = vec[k].s[2]; sin3_i = vec[k].s[3];
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input int k);
        int  guard;
        logic acc;
        drive_vec(k);
        s_valid_i = 1'b1;
        guard = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk_i);
            acc = s_ready_o;
            @(posedge clk_i);
            guard++;
            if (guard > 100) begin
                $display("FAIL send_timeout: s_ready_o stuck low for %0d cycles", guard);
                $fatal(1, "input never accepted");
            end
        end
        exp_q.push_back({vec[k].sat, vec[k].dac});
        #1 s_valid_i = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(posedge clk_i);
            g++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_latency(input int k);
        @(posedge clk_i);
        #1;
        drive_vec(k);
        s_valid_i = 1'b1;
        @(posedge clk_i);
        exp_q.push_back({vec[k].sat, vec[k].dac});
        #1 s_valid_i = 1'b0;
        chk("lat_edge1_valid", 64'(m_valid_o), 64'd0);
        @(posedge clk_i);
        #1 chk("lat_edge2_valid", 64'(m_valid_o), 64'd0);
        @(posedge clk_i);
        #1 chk("lat_edge3_valid", 64'(m_valid_o), 64'd1);
    endtask

    // Output scoreboard: every completed handshake must match the next expected beat.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("s_ready_rule", 64'(s_ready_o), 64'(!(m_valid_o && !m_ready_i)));
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(out_w), 64'd0);
                end else begin
                    logic [51:0] e;
                    e = exp_q.pop_front();
                    chk("beat", 64'(out_w), 64'(e));
                    if ((|e[51:48]) && exp_cnt != 65535) exp_cnt++;
                    if (cnt_chk) chk("sat_count", 64'(sat_count_o), 64'(exp_cnt));
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < NV; k++) vec[k] = '0;
        set_lane(0, 0, 16384, 0, 32767, 0, 1024, 0);
        set_lane(1, 0, 0, 16384, 0, 32767, -1024, 0);
        set_lane(2, 0, 8192, 0, 16384, 0, 256, 0);
        set_lane(2, 1, 0, 8192, 0, 16384, -256, 0);
        set_lane(2, 2, -4096, 0, 16384, 0, -128, 0);
        set_lane(2, 3, 16384, -16384, 16384, 16384, 1024, 0);
        set_lane(3, 1, 32767, -32768, 32767, 32767, 2047, 1);
        set_lane(4, 2, -32768, 32767, 32767, 32767, -2048, 1);
        set_lane(5, 0, 32767, -32768, 32767, 32767, 2047, 1);
        set_lane(5, 3, -32768, 32767, 32767, 32767, -2048, 1);
        set_lane(6, 0, 512, 0, 512, 0, 1, 0);
        set_lane(6, 1, -512, 0, 512, 0, 0, 0);
        set_lane(6, 2, 32752, -32752, 16384, 16384, 2047, 0);
        set_lane(6, 3, -32768, -32768, 16384, -16384, -2048, 0);
        set_lane(7, 0, -32768, -32768, -32768, 32767, 2047, 1);
        set_lane(7, 1, -32768, -32768, 32767, -32768, -2048, 1);
        set_lane(7, 2, -32768, -32768, -16384, 16384, 2047, 1);
        // vec[8] stays all-zero: expected dac 0, no saturation.

        // Reset with random inputs
        s_valid_i = 1'b1;
        m_ready_i = 1'($urandom_range(0, 1));
        i0_i = 16'($urandom); q1_i = 16'($urandom); cos2_i = 16'($urandom); sin3_i = 16'($urandom);
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_m_valid", 64'(m_valid_o), 64'd0);
        chk("rst_dac", 64'({dac3_o, dac2_o, dac1_o, dac0_o}), 64'd0);
        chk("rst_m_sat", 64'(m_sat_o), 64'd0);
        chk("rst_sat_count", 64'(sat_count_o), 64'd0);
        chk("rst_s_ready", 64'(s_ready_o), 64'd1);
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 chk("idle_m_valid", 64'(m_valid_o), 64'd0);

        check_latency(0);
        drain();

        // Table vectors back-to-back
        for (int k = 0; k < NV; k++) send_beat(k);
        drain();

        // Backpressure: 8 distinct beats with a 5-cycle downstream stall
        fork
            begin
                for (int k = 0; k < 8; k++) send_beat(k);
            end
            begin
                repeat (4) @(posedge clk_i);
                #1 m_ready_i = 1'b0;
                @(negedge clk_i);
                snap = out_w;
                chk("stall_s_ready", 64'(s_ready_o), 64'd0);
                repeat (4) begin
                    @(negedge clk_i);
                    chk("stall_valid", 64'(m_valid_o), 64'd1);
                    chk("stall_hold", 64'(out_w), 64'(snap));
                end
                @(posedge clk_i);
                #1 m_ready_i = 1'b1;
            end
        join
        drain();

        // Clear in the same cycle as a saturated increment
        cnt_chk = 1'b0;
        @(posedge clk_i);
        #1;
        drive_vec(3);
        s_valid_i = 1'b1;
        @(posedge clk_i);
        exp_q.push_back({vec[3].sat, vec[3].dac});
        #1 s_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("pre_clr_count", 64'(sat_count_o), 64'(exp_cnt));
        sat_clr_i = 1'b1;
        @(posedge clk_i);
        #1 sat_clr_i = 1'b0;
        chk("clr_valid", 64'(m_valid_o), 64'd1);
        chk("clr_m_sat", 64'(m_sat_o), 64'h2);
        chk("clr_priority", 64'(sat_count_o), 64'd0);
        @(negedge clk_i);
        #1;
        exp_cnt = 0;
        cnt_chk = 1'b1;
        drain();

        // Counter sticks at 65535
        for (int n = 0; n < 65535; n++) send_beat(5);
        drain();
        chk("count_full", 64'(sat_count_o), 64'd65535);
        for (int n = 0; n < 3; n++) send_beat(7);
        drain();
        chk("count_sticky", 64'(sat_count_o), 64'd65535);

        // Reset mid-stream
        for (int n = 0; n < 4; n++) send_beat(4);
        drive_vec(3);
        s_valid_i = 1'b1;
        #1 rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_valid_o), 64'd0);
        chk("mid_rst_count", 64'(sat_count_o), 64'd0);
        chk("mid_rst_out", 64'(out_w), 64'd0);
        chk("mid_rst_s_ready", 64'(s_ready_o), 64'd1);
        exp_q.delete();
        exp_cnt = 0;
        repeat (2) @(posedge clk_i);
        s_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check_latency(2);
        drain();
        chk("post_rst_count", 64'(sat_count_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
